fetch_stage: RTL and testbench

Instruction-fetch stage control for the LC-3b five-stage pipeline. Each cycle it takes the current PC and the instruction word from instruction memory, and computes the next PC. It also produces the values and load enables for the PC register and the DE pipeline latch, which both live outside the block. The block sits between instruction memory and the decode latch, and takes its stall and redirect inputs from the downstream stages.

---
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction-fetch control.
// Computes next PC, PC load enable, and the next DE latch contents
// (NPC, IR, V) plus its load enable. All of these outputs are combinational
// and do not depend on rst_n. The PC register and the DE latch live outside
// this block.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   : saturating 16-bit fetch/bubble/redirect counters on clk,
//               asynchronously cleared by rst_n.
//   undefined : counters not built, outputs tied to 0, clk/rst_n unused.
//
// Ports:
//   clk, rst_n            clock / async active-low reset (counters only)
//   pc                    current PC
//   dep_stall, mem_stall  downstream stalls
//   v_*_br_stall          control instruction in DE / AGEX / MEM
//   imem_r                instruction memory ready
//   mem_pcmux             PC source selected by MEM
//   target_pc, trap_pc    redirect targets
//   instr                 fetched instruction word
//   ld_pc, new_pc         PC register load enable / value
//   de_npc, de_ir, de_v   next DE latch contents
//   ld_de                 DE latch load enable
//   fetch_cnt, bubble_cnt, redirect_cnt  performance counters
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic        imem_r,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  input  logic [15:0] instr,
  output logic        ld_pc,
  output logic [15:0] new_pc,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v,
  output logic        ld_de,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt,
  output logic [15:0] redirect_cnt
);

  logic [15:0] pc_plus2;
  logic        br_stall;
  logic        redirect;
  logic        advance;

  always_comb begin
    pc_plus2 = pc + 16'd2;
    br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    // A redirect wins over dep/br stalls and imem_r, but mem_stall freezes it.
    redirect = ((mem_pcmux == 2'd1) || (mem_pcmux == 2'd2)) && !mem_stall;
    advance  = imem_r && !dep_stall && !mem_stall && !br_stall;

    case (mem_pcmux)
      2'd1:    new_pc = target_pc;
      2'd2:    new_pc = trap_pc;
      default: new_pc = pc_plus2;
    endcase

    ld_pc  = redirect | advance;
    de_npc = pc_plus2;
    de_ir  = instr;
    de_v   = imem_r & !br_stall;
    ld_de  = !dep_stall & !mem_stall;
  end

  // RESET_PC only documents the external PC register's boot value.
  logic unused_param;
  assign unused_param = ^RESET_PC;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q,    fetch_cnt_d;
  logic [15:0] bubble_cnt_q,   bubble_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (ld_de && de_v && (fetch_cnt_q != 16'hFFFF))
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (ld_de && !de_v && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    if (redirect && (redirect_cnt_q != 16'hFFFF))
      redirect_cnt_d = redirect_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 16'h0000;
      bubble_cnt_q   <= 16'h0000;
      redirect_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      bubble_cnt_q   <= bubble_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign fetch_cnt    = 16'h0000;
  assign bubble_cnt   = 16'h0000;
  assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        dep_stall, mem_stall;
  logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
  logic        imem_r;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc, trap_pc, instr;
  logic        ld_pc, de_v, ld_de;
  logic [15:0] new_pc, de_npc, de_ir;
  logic [15:0] fetch_cnt, bubble_cnt, redirect_cnt;

  fetch_stage #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .imem_r(imem_r), .mem_pcmux(mem_pcmux),
    .target_pc(target_pc), .trap_pc(trap_pc), .instr(instr),
    .ld_pc(ld_pc), .new_pc(new_pc), .de_npc(de_npc), .de_ir(de_ir),
    .de_v(de_v), .ld_de(ld_de), .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference counter state and last expected per-cycle events
  int m_fetch = 0, m_bubble = 0, m_redir = 0;
  bit e_fetch_ev, e_bubble_ev, e_redir_ev;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the fetch rules written directly as arithmetic / truth values.
  task automatic check_comb();
    int  seq_pc;
    int  exp_new;
    bit  any_br, take_redirect, can_advance, exp_dev, exp_ldde;
    seq_pc        = (int'(pc) + 2) % 65536;
    any_br        = (v_de_br_stall + v_agex_br_stall + v_mem_br_stall) > 0;
    take_redirect = (mem_pcmux inside {2'd1, 2'd2}) && (mem_stall == 1'b0);
    can_advance   = imem_r && !dep_stall && !mem_stall && !any_br;
    exp_new       = (mem_pcmux == 2'd1) ? int'(target_pc) :
                    (mem_pcmux == 2'd2) ? int'(trap_pc) : seq_pc;
    exp_dev       = imem_r && !any_br;
    exp_ldde      = !(dep_stall || mem_stall);
    chk("new_pc", new_pc, 16'(exp_new));
    chk("ld_pc",  {15'd0, ld_pc}, {15'd0, take_redirect || can_advance});
    chk("de_npc", de_npc, 16'(seq_pc));
    chk("de_ir",  de_ir, instr);
    chk("de_v",   {15'd0, de_v}, {15'd0, exp_dev});
    chk("ld_de",  {15'd0, ld_de}, {15'd0, exp_ldde});
    e_fetch_ev  = exp_ldde && exp_dev;
    e_bubble_ev = exp_ldde && !exp_dev;
    e_redir_ev  = take_redirect;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fetch"},  fetch_cnt,    CNT_EN ? 16'(m_fetch)  : 16'h0);
    chk({tag, "_bubble"}, bubble_cnt,   CNT_EN ? 16'(m_bubble) : 16'h0);
    chk({tag, "_redir"},  redirect_cnt, CNT_EN ? 16'(m_redir)  : 16'h0);
  endtask

  // Called just after a negedge with inputs driven; returns after the next negedge.
  task automatic step(input bit check_cnt);
    #1 check_comb();
    @(posedge clk);
    if (rst_n) begin
      if (e_fetch_ev)  m_fetch  = (m_fetch  < 65535) ? m_fetch  + 1 : 65535;
      if (e_bubble_ev) m_bubble = (m_bubble < 65535) ? m_bubble + 1 : 65535;
      if (e_redir_ev)  m_redir  = (m_redir  < 65535) ? m_redir  + 1 : 65535;
    end
    #1 if (check_cnt) chk_cnt("cnt");
    @(negedge clk);
  endtask

  task automatic set_normal();
    pc = 16'h3000; instr = 16'h1234; imem_r = 1'b1;
    dep_stall = 1'b0; mem_stall = 1'b0;
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
    mem_pcmux = 2'd0; target_pc = 16'h4000; trap_pc = 16'h0200;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 m_fetch = 0; m_bubble = 0; m_redir = 0;
    chk_cnt(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_normal();
    #3 chk_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // normal flow
    set_normal();
    #1 chk("tp_norm_new_pc", new_pc, 16'h3002);
    chk("tp_norm_ld_pc", {15'd0, ld_pc}, 16'd1);
    chk("tp_norm_de_v",  {15'd0, de_v},  16'd1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    // memory not ready x2
    imem_r = 1'b0;
    #1 chk("tp_nrdy_ld_pc", {15'd0, ld_pc}, 16'd0);
    chk("tp_nrdy_ld_de", {15'd0, ld_de}, 16'd1);
    step(1'b1);
    step(1'b1);
    // branch resolve redirect
    imem_r = 1'b1; v_mem_br_stall = 1'b1; mem_pcmux = 2'd1;
    #1 chk("tp_br_new_pc", new_pc, 16'h4000);
    chk("tp_br_ld_pc", {15'd0, ld_pc}, 16'd1);
    chk("tp_br_de_v",  {15'd0, de_v},  16'd0);
    step(1'b1);
    chk("tp_seq_fetch",  fetch_cnt,    CNT_EN ? 16'd3 : 16'd0);
    chk("tp_seq_bubble", bubble_cnt,   CNT_EN ? 16'd3 : 16'd0);
    chk("tp_seq_redir",  redirect_cnt, CNT_EN ? 16'd1 : 16'd0);
    // trap
    mem_pcmux = 2'd2;
    #1 chk("tp_trap_new_pc", new_pc, 16'h0200);
    step(1'b1);
    // stalls
    set_normal(); dep_stall = 1'b1;
    #1 chk("tp_dep_ld_pc", {15'd0, ld_pc}, 16'd0);
    chk("tp_dep_ld_de", {15'd0, ld_de}, 16'd0);
    step(1'b1);
    mem_pcmux = 2'd1;
    #1 chk("tp_dep_redir_ld_pc", {15'd0, ld_pc}, 16'd1);
    step(1'b1);
    set_normal(); mem_stall = 1'b1; mem_pcmux = 2'd1;
    #1 chk("tp_mem_ld_pc", {15'd0, ld_pc}, 16'd0);
    step(1'b1);
    mem_stall = 1'b0;
    step(1'b1);
    // wrap and reserved mux value
    set_normal(); pc = 16'hFFFE;
    #1 chk("tp_wrap_new_pc", new_pc, 16'h0000);
    chk("tp_wrap_de_npc", de_npc, 16'h0000);
    step(1'b1);
    pc = 16'h1000; mem_pcmux = 2'd3;
    #1 chk("tp_mux3_new_pc", new_pc, 16'h1002);
    step(1'b1);

    mid_cycle_reset("midrst");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pc              = 16'($urandom);
      instr           = 16'($urandom);
      target_pc       = 16'($urandom);
      trap_pc         = 16'($urandom);
      mem_pcmux       = 2'($urandom_range(0, 3));
      imem_r          = ($urandom_range(0, 3) != 0);
      dep_stall       = ($urandom_range(0, 3) == 0);
      mem_stall       = ($urandom_range(0, 3) == 0);
      v_de_br_stall   = ($urandom_range(0, 5) == 0);
      v_agex_br_stall = ($urandom_range(0, 5) == 0);
      v_mem_br_stall  = ($urandom_range(0, 5) == 0);
      if (i % 8 == 0) pc = 16'hFFFE;
      step(1'b1);
    end

`ifdef FETCH_PERF_CNT_EN
    // saturation of fetch_cnt; the other counters hold
    mid_cycle_reset("satrst");
    set_normal();
    repeat (65540) @(posedge clk);
    m_fetch = 65535;
    #1 chk_cnt("sat");
    @(negedge clk);
    step(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
